load_store_unit: RTL

Multi-cycle data-memory access unit for the RV32I core. It sits directly downstream of the ALU: the ALU's ADD result is the effective address, and this unit turns it into a word-aligned data-bus transaction. It formats store lanes and strobes, extracts and sign- or zero-extends load data, and reports alignment, encoding and bus-timeout faults. The core stalls on `busy` and writes back `rdata` on `done`.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle RV32I data-memory access unit. Turns the ALU
//                effective address into a word-aligned bus transaction,
//                formats store lanes/strobes, extends load data and reports
//                misaligned, illegal-funct3 and bus-timeout faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [1:0] c_CAUSE_NONE     = 2'd0;
    localparam logic [1:0] c_CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] c_CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'd3;

    // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit.
    localparam int                 c_CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic               c_TO_EN    = (TIMEOUT_CYCLES > 0);

    logic [1:0]         r_state, w_state_nxt;
    logic [1:0]         r_cause, w_cause_nxt;
    logic [c_CNT_W-1:0] r_wait,  w_wait_nxt;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic [31:0]        r_wdata;
    logic               r_is_store;
    logic [31:0]        r_rdata;

    logic               w_accept;
    logic               w_capture;
    logic [1:0]         w_req_cause;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_wstrb;
    logic               w_in_req;
    logic               w_done;

    // Classify the incoming request: illegal encoding wins over misalignment.
    always_comb begin
        w_req_cause = c_CAUSE_NONE;
        if (req_is_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                         : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'd6))) begin
            w_req_cause = c_CAUSE_ILLEGAL;
        end else if (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))) begin
            w_req_cause = c_CAUSE_MISALIGN;
        end
    end

    // Next-state logic; a timeout fires on the last allowed unanswered REQ cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_wait_nxt  = r_wait;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cause_nxt = w_req_cause;
                    w_wait_nxt  = '0;
                    w_state_nxt = (w_req_cause != c_CAUSE_NONE) ? c_ST_RESP : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (mem_ready) begin
                    w_capture   = 1'b1;
                    w_cause_nxt = c_CAUSE_NONE;
                    w_state_nxt = c_ST_RESP;
                end else begin
                    if (r_wait != c_CNT_MAX) begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                    if (c_TO_EN && (r_wait == c_CNT_LAST)) begin
                        w_cause_nxt = c_CAUSE_TIMEOUT;
                        w_state_nxt = c_ST_RESP;
                    end
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM state, fault cause and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cause <= c_CAUSE_NONE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Latch the request on acceptance and the extended load data on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_funct3   <= '0;
            r_wdata    <= '0;
            r_is_store <= 1'b0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_funct3   <= req_funct3;
            r_wdata    <= req_wdata;
            r_is_store <= req_is_store;
            r_rdata    <= '0;
        end else if (w_capture) begin
            r_rdata    <= r_is_store ? 32'd0 : w_load_data;
        end
    end

    // Select the addressed lane of the bus word and extend it.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd2:    w_load_data = mem_rdata;
            3'd4:    w_load_data = {24'd0, w_byte};
            3'd5:    w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    // Replicate store data across lanes and build the byte strobes.
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{r_wdata[7:0]}};
                w_st_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{r_wdata[15:0]}};
                w_st_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = r_wdata;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_in_req    = (r_state == c_ST_REQ);
    assign w_done      = (r_state == c_ST_RESP);
    assign busy        = (r_state != c_ST_IDLE);
    assign done        = w_done;
    assign fault       = w_done && (r_cause != c_CAUSE_NONE);
    assign fault_cause = w_done ? r_cause : c_CAUSE_NONE;
    assign rdata       = w_done ? r_rdata : 32'd0;
    assign mem_valid   = w_in_req;
    assign mem_addr    = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_we      = w_in_req && r_is_store;
    assign mem_wstrb   = (w_in_req && r_is_store) ? w_st_wstrb : 4'd0;
    assign mem_wdata   = (w_in_req && r_is_store) ? w_st_wdata : 32'd0;

endmodule
`default_nettype wire
